// File: rtl/sub_stream_q13_if.sv
// Stream bundle for the modular subtractor.
//   master : producer/consumer side. Drives in_valid, in_a, in_b and out_ready.
//   slave  : subtractor side. Drives in_ready, the out_* result fields and busy.
interface sub_stream_q13_if #(
   parameter int unsigned NUM_BIT = 13,
   parameter int unsigned CNT_W   = 10
);
   logic               in_valid;
   logic               in_ready;
   logic [NUM_BIT-1:0] in_a;
   logic [NUM_BIT-1:0] in_b;
   logic               out_valid;
   logic               out_ready;
   logic [NUM_BIT-1:0] out_d;
   logic               out_borrow;
   logic               out_last;
   logic [CNT_W-1:0]   out_idx;
   logic               busy;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_d, out_borrow, out_last, out_idx, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_d, out_borrow, out_last, out_idx, busy
   );
endinterface

// File: rtl/sub_stream_q13.sv
// Streaming modular subtractor, d = (a - b) mod 2^NUM_BIT, for polynomial coefficients.
// Two-stage valid/ready pipeline. S1 holds the operands, the frame index and the last
// tag. S2 holds the difference from a Sklansky prefix adder evaluating a + ~b + 1.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave modport of sub_stream_q13_if
//          in_valid/in_ready/in_a/in_b : operand stream
//          out_valid/out_ready/out_d/out_borrow/out_last/out_idx : result stream
//          busy : any stage holds a beat
module sub_stream_q13 #(
   parameter int unsigned NUM_BIT = 13,
   parameter int unsigned N_COEF  = 701,
   parameter int unsigned CNT_W   = 10
) (
   input logic             clk,
   input logic             rst,
   sub_stream_q13_if.slave bus
);

   // Prefix primitives: generate/propagate pairs combined Sklansky style.
   function automatic logic [1:0] ha(input logic x, input logic y);
      return {x & y, x ^ y};  // {g, p}
   endfunction

   function automatic logic grey_cell(input logic gi, input logic pi, input logic gj);
      return gi | (pi & gj);
   endfunction

   function automatic logic [1:0] black_cell(input logic gi, input logic pi,
                                             input logic gj, input logic pj);
      return {gi | (pi & gj), pi & pj};
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic               s1_valid_q, s1_valid_d;
   logic [NUM_BIT-1:0] s1_a_q, s1_a_d;
   logic [NUM_BIT-1:0] s1_b_q, s1_b_d;
   logic [CNT_W-1:0]   s1_idx_q, s1_idx_d;
   logic               s1_last_q, s1_last_d;

   logic               s2_valid_q, s2_valid_d;
   logic [NUM_BIT-1:0] s2_d_q, s2_d_d;
   logic               s2_borrow_q, s2_borrow_d;
   logic [CNT_W-1:0]   s2_idx_q, s2_idx_d;
   logic               s2_last_q, s2_last_d;

   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic in_ready;
   logic s1_load;
   logic s2_load;
   logic cnt_at_end;

   assign in_ready   = ~rst & (~s1_valid_q | ~s2_valid_q | bus.out_ready);
   assign s1_load    = bus.in_valid & in_ready;
   assign s2_load    = s1_valid_q & (~s2_valid_q | bus.out_ready);
   assign cnt_at_end = (cnt_q == CNT_W'(N_COEF - 1));

   // ------------------------------------------------------------------
   // Prefix network between S1 and S2: a + ~b + 1
   // ------------------------------------------------------------------
   logic [NUM_BIT-1:0] g0;
   logic [NUM_BIT-1:0] p0;
   logic [NUM_BIT-1:0] carry;  // carry[i] is the carry out of bit i
   logic [NUM_BIT-1:0] diff;
   logic               carry_out;

   always_comb begin
      logic [NUM_BIT-1:0] g, p, g_n, p_n;
      logic [1:0]         gp;
      int                 j;
      g0 = '0;
      p0 = '0;
      for (int i = 0; i < int'(NUM_BIT); i++) begin
         gp    = ha(s1_a_q[i], ~s1_b_q[i]);
         g0[i] = gp[1];
         p0[i] = gp[0];
      end
      g = g0;
      p = p0;
      // Forced carry-in of 1 folds into bit 0, so group 0 is already complete.
      g[0] = grey_cell(g0[0], p0[0], 1'b1);
      for (int l = 0; (1 << l) < int'(NUM_BIT); l++) begin
         g_n = g;
         p_n = p;
         for (int i = 0; i < int'(NUM_BIT); i++) begin
            if (((i >> l) & 1) == 1) begin
               j = ((i >> l) << l) - 1;
               // Once the combined span reaches bit 0 only the generate term matters.
               if ((i >> (l + 1)) == 0) begin
                  g_n[i] = grey_cell(g[i], p[i], g[j]);
               end else begin
                  gp     = black_cell(g[i], p[i], g[j], p[j]);
                  g_n[i] = gp[1];
                  p_n[i] = gp[0];
               end
            end
         end
         g = g_n;
         p = p_n;
      end
      carry = g;
   end

   assign diff      = p0 ^ {carry[NUM_BIT-2:0], 1'b1};
   assign carry_out = carry[NUM_BIT-1];

   // ------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_idx_d   = s1_idx_q;
      s1_last_d  = s1_last_q;
      cnt_d      = cnt_q;

      if (s1_load) begin
         s1_valid_d = 1'b1;
         s1_a_d     = bus.in_a;
         s1_b_d     = bus.in_b;
         s1_idx_d   = cnt_q;
         s1_last_d  = cnt_at_end;
         cnt_d      = cnt_at_end ? '0 : cnt_q + 1'b1;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      s2_valid_d  = s2_valid_q;
      s2_d_d      = s2_d_q;
      s2_borrow_d = s2_borrow_q;
      s2_idx_d    = s2_idx_q;
      s2_last_d   = s2_last_q;

      if (s2_load) begin
         s2_valid_d  = 1'b1;
         s2_d_d      = diff;
         s2_borrow_d = ~carry_out;
         s2_idx_d    = s1_idx_q;
         s2_last_d   = s1_last_q;
      end else if (bus.out_ready) begin
         // Drained without a replacement; data fields stay put.
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_idx_q    <= '0;
         s1_last_q   <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_d_q      <= '0;
         s2_borrow_q <= 1'b0;
         s2_idx_q    <= '0;
         s2_last_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_idx_q    <= s1_idx_d;
         s1_last_q   <= s1_last_d;
         s2_valid_q  <= s2_valid_d;
         s2_d_q      <= s2_d_d;
         s2_borrow_q <= s2_borrow_d;
         s2_idx_q    <= s2_idx_d;
         s2_last_q   <= s2_last_d;
         cnt_q       <= cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = s2_valid_q;
   assign bus.out_d      = s2_d_q;
   assign bus.out_borrow = s2_borrow_q;
   assign bus.out_last   = s2_last_q;
   assign bus.out_idx    = s2_idx_q;
   assign bus.busy       = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_sub_stream_q13.sv
module tb_sub_stream_q13;
   localparam int unsigned NUM_BIT = 13;
   localparam int unsigned N_COEF  = 701;
   localparam int unsigned CNT_W   = 10;
   localparam int          MODV    = 1 << NUM_BIT;

   typedef struct packed {
      logic [NUM_BIT-1:0] d;
      logic               borrow;
      logic [CNT_W-1:0]   idx;
      logic               last;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sub_stream_q13_if #(.NUM_BIT(NUM_BIT), .CNT_W(CNT_W)) bus ();

   sub_stream_q13 #(.NUM_BIT(NUM_BIT), .N_COEF(N_COEF), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int    n_tests = 0;
   int    n_fail  = 0;
   int    n_out   = 0;
   int    n_last  = 0;
   beat_t exp_q[$];
   int    model_cnt = 0;
   logic  stall_prev = 1'b0;
   beat_t held;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer subtraction and a frame position counter.
   function automatic beat_t model(input int a, input int b, input int idx);
      beat_t r;
      int    diff;
      diff     = a - b;
      r.d      = NUM_BIT'((diff + MODV) % MODV);
      r.borrow = (a < b);
      r.idx    = CNT_W'(idx);
      r.last   = (idx == int'(N_COEF) - 1);
      return r;
   endfunction

   function automatic beat_t cur_out();
      beat_t r;
      r.d      = bus.out_d;
      r.borrow = bus.out_borrow;
      r.idx    = bus.out_idx;
      r.last   = bus.out_last;
      return r;
   endfunction

   // Compare process: handshakes seen here complete at the next rising edge.
   always @(negedge clk) begin
      beat_t e;
      #1;
      if (rst) begin
         exp_q.delete();
         model_cnt  = 0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_data", 32'(cur_out()), 32'(held));
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(int'(bus.in_a), int'(bus.in_b), model_cnt));
            model_cnt = (model_cnt == int'(N_COEF) - 1) ? 0 : model_cnt + 1;
         end
         if (bus.out_valid) begin
            if (bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_beat", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat", 32'(cur_out()), 32'(e));
                  n_out++;
                  if (bus.out_last) n_last++;
               end
               stall_prev = 1'b0;
            end else begin
               stall_prev = 1'b1;
               held       = cur_out();
            end
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   task automatic send(input logic [NUM_BIT-1:0] a, input logic [NUM_BIT-1:0] b,
                       output int stalls);
      int   tries;
      logic acc;
      tries  = 0;
      stalls = 0;
      do begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_a     = a;
         bus.in_b     = b;
         #1;
         acc = bus.in_ready;
         if (!acc) stalls++;
         @(posedge clk);
         tries++;
      end while (!acc && tries < 100);
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic expect_out(input int d, input int borrow, input int idx, input int last,
                             output int waited);
      waited = 0;
      do begin
         @(negedge clk);
         #1;
         waited++;
      end while (!bus.out_valid && waited < 10);
      chk("exp_found", 32'(bus.out_valid), 32'd1);
      chk("exp_d", 32'(bus.out_d), 32'(d));
      chk("exp_borrow", 32'(bus.out_borrow), 32'(borrow));
      chk("exp_idx", 32'(bus.out_idx), 32'(idx));
      chk("exp_last", 32'(bus.out_last), 32'(last));
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while ((exp_q.size() != 0 || bus.busy) && n < 50);
      chk("drain", 32'(exp_q.size() == 0 && !bus.busy), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int st, stalls, w, acc, out0, last0;
      logic accp;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_d", 32'(bus.out_d), 32'd0);
      chk("rst_borrow", 32'(bus.out_borrow), 32'd0);
      chk("rst_last", 32'(bus.out_last), 32'd0);
      chk("rst_idx", 32'(bus.out_idx), 32'd0);
      rst = 1'b0;
      #1;
      chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

      // Single beat, 2-cycle latency
      bus.out_ready = 1'b1;
      send(13'd100, 13'd30, st);
      idle();
      #1;
      chk("fill_no_valid", 32'(bus.out_valid), 32'd0);
      expect_out(70, 0, 0, 0, w);
      chk("latency", 32'(w), 32'd1);

      // Wrap-around cases
      send(13'd5, 13'd9, st);
      idle();
      expect_out(8188, 1, 1, 0, w);
      send(13'd0, 13'd8191, st);
      idle();
      expect_out(1, 1, 2, 0, w);
      send(13'd8191, 13'd8191, st);
      idle();
      expect_out(0, 0, 3, 0, w);
      drain();

      // Two back-to-back frames at full rate
      do_reset();
      out0   = n_out;
      last0  = n_last;
      stalls = 0;
      for (int k = 0; k < 2 * int'(N_COEF); k++) begin
         send(NUM_BIT'($urandom), NUM_BIT'($urandom), st);
         stalls += st;
      end
      idle();
      @(negedge clk);
      #2;
      chk("ff_stalls", 32'(stalls), 32'd0);
      chk("ff_outputs", 32'(n_out - out0), 32'(2 * N_COEF));
      chk("ff_lasts", 32'(n_last - last0), 32'd2);
      drain();

      // Backpressure: only two beats fit
      bus.out_ready = 1'b0;
      acc  = 0;
      accp = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0 || accp) begin
            bus.in_a = NUM_BIT'(1000 + k);
            bus.in_b = NUM_BIT'(3000 - k);
         end
         bus.in_valid = 1'b1;
         #1;
         accp = bus.in_ready;
         if (accp) acc++;
      end
      chk("bp_accepted", 32'(acc), 32'd2);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      drain();

      // Random valid/ready
      accp = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (!bus.in_valid || accp) begin
            bus.in_valid = 1'($urandom);
            bus.in_a     = NUM_BIT'($urandom);
            bus.in_b     = NUM_BIT'($urandom);
         end
         bus.out_ready = 1'($urandom);
         #1;
         accp = bus.in_valid && bus.in_ready;
      end
      @(negedge clk);
      drain();

      // Reset mid-frame
      do_reset();
      for (int k = 0; k < 300; k++) send(NUM_BIT'($urandom), NUM_BIT'($urandom), st);
      #2;
      chk("mid_busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_busy", 32'(bus.busy), 32'd0);
      chk("mid_in_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst   = 1'b0;
      last0 = n_last;
      send(13'd77, 13'd7, st);
      idle();
      expect_out(70, 0, 0, 0, w);
      for (int k = 1; k < int'(N_COEF); k++) send(NUM_BIT'($urandom), NUM_BIT'($urandom), st);
      idle();
      drain();
      chk("mid_frame_last", 32'(n_last - last0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/sub_stream_q13.md
Name: sub_stream_q13

Overview:
- Streaming modular subtractor for NTRU-HRSS polynomial coefficients, mod q = 2^13.
- Per accepted beat, computes d = (a − b) mod 8192.
- Computation is a + ~b + 1 through a Sklansky parallel-prefix carry network (ha / grey_cell / black_cell primitives), carry-in forced to 1.
- Sits between the coefficient RAM readers and the polynomial-result writer. It is the inverse operation of the coefficient adder path and tags frame boundaries every N_COEF coefficients.

Parameters:
- NUM_BIT, 13, coefficient width; modulus is 2^NUM_BIT.
- N_COEF, 701, coefficients per polynomial frame; must be ≥ 2.
- CNT_W, 10, width of the coefficient index counter; must satisfy 2^CNT_W ≥ N_COEF.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  NUM_BIT  minuend coefficient.
- in_b  in  NUM_BIT  subtrahend coefficient.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_d  out  NUM_BIT  (in_a − in_b) mod 2^NUM_BIT.
- out_borrow  out  1  1 when in_a < in_b, i.e. prefix carry-out is 0.
- out_last  out  1  result is coefficient N_COEF−1 of its frame.
- out_idx  out  CNT_W  frame index of the result beat.
- busy  out  1  any pipeline stage holds a valid beat.

Behaviour:
- Reset is asynchronous and active-high. While rst=1 and on release:
  - out_valid=0, out_d=0, out_borrow=0, out_last=0, out_idx=0, busy=0.
  - All stage-valid flags are 0 and the input counter is 0.
  - in_ready is 0 while rst=1.
- Handshakes:
  - An input transfer occurs when in_valid & in_ready at a rising edge.
  - An output transfer occurs when out_valid & out_ready at a rising edge.
- Pipeline structure:
  - Stage S1 registers in_a, in_b, the frame index and the last tag.
  - Stage S2 registers the prefix-network result (out_d, out_borrow) plus the index and last tag.
  - The prefix network is combinational between S1 and S2.
- Latency: 2 cycles from input transfer to out_valid, when not stalled.
- Stage advance rules:
  - s2_load = s1_valid & (!s2_valid | out_ready).
  - s1_load = in_valid & in_ready.
  - in_ready = !rst & (!s1_valid | !s2_valid | out_ready).
  - in_ready depends combinationally on out_ready; this is an allowed path.
- Throughput is 1 beat per cycle when out_ready is held at 1.
- Stall and ordering:
  - A stalled stage holds its data stable.
  - out_d, out_borrow, out_last and out_idx must not change while out_valid=1 and out_ready=0.
  - No beat is ever dropped or duplicated; output order equals input order.
- Index counter:
  - Increments on each input transfer.
  - When it equals N_COEF−1, the beat is tagged last and the counter wraps to 0.
  - Back-to-back frames need no idle cycle.
- Arithmetic:
  - d = a + (~b) + 1, truncated to NUM_BIT bits.
  - out_borrow = !carry_out.
  - Examples: a == b gives d=0, borrow=0. a=0, b=1 gives d=8191, borrow=1.
- Simultaneous events:
  - With S2 full and out_ready=1, S2 drains and reloads from S1 in the same edge, and S1 reloads from the input in the same edge.
- Reset mid-frame:
  - All in-flight beats are discarded and the counter returns to 0.
  - The next accepted beat is index 0.
- busy = s1_valid | s2_valid.

Test Plan:
- Single beat: rst pulse, then a=100, b=30, out_ready=1 → two cycles later out_d=70, borrow=0, idx=0, last=0.
- Wrap-around: a=5, b=9 → out_d=8188, borrow=1. Then a=0, b=8191 → out_d=1, borrow=1. Then a=8191, b=8191 → out_d=0, borrow=0.
- Full frame, back-to-back: stream 2·N_COEF random beats at 1/cycle with out_ready=1.
  - Results match a reference model every beat.
  - out_last=1 exactly at idx=700 and at the second frame's idx=700.
  - The beat after each last has idx=0.
  - No bubbles after the initial 2-cycle fill.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1.
  - Exactly 2 beats are accepted, then in_ready=0.
  - Outputs stay stable during the stall.
  - On release, all beats arrive in order with no loss or duplication.
- Random valid/ready toggling: 50% in_valid and 50% out_ready over 3000 cycles → scoreboard matches, ordering preserved, last tags correct.
- Reset mid-frame: accept 300 beats, assert rst asynchronously between edges.
  - out_valid and busy drop immediately.
  - After release, the first beat is reported idx=0 and the frame completes with last at idx=700.
